// File: rtl/theremin_arith_pkg.sv
// Shared arithmetic definitions for the theremin ratio path: multiplier state
// encoding plus fixed-point scale and saturation-limit helpers.
package theremin_arith_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READY,
    ST_CAPTURE,
    ST_MUL,
    ST_FINISH,
    ST_DONE
  } mul_state_t;

  // Value of 1.0 in a signed Q1.(fb-1) fraction.
  function automatic longint unsigned frac_one(input int fb);
    return longint'(1) << (fb - 1);
  endfunction

  // Half an LSB of the fraction scale; the rounding bias for the final shift.
  function automatic longint unsigned frac_half(input int fb);
    return longint'(1) << (fb - 2);
  endfunction

  function automatic longint unsigned sat_max_pos(input int ob);
    return (longint'(1) << (ob - 1)) - 1;
  endfunction

  // Magnitude of the most negative representable result.
  function automatic longint unsigned sat_min_mag(input int ob);
    return longint'(1) << (ob - 1);
  endfunction

endpackage

// File: rtl/frac_round_sat.sv
// Turns an unsigned magnitude product plus a sign into a rounded (half away
// from zero), saturated signed result at the operand width.
module frac_round_sat
  import theremin_arith_pkg::*;
#(
  parameter int FRAC_BITS    = 25,
  parameter int OPERAND_BITS = 30
) (
  input  logic [FRAC_BITS+OPERAND_BITS-1:0] mag,
  input  logic                              neg,
  output logic signed [OPERAND_BITS-1:0]    result
);

  localparam int PW = FRAC_BITS + OPERAND_BITS;

  localparam logic [PW:0] HALF    = (PW+1)'(frac_half(FRAC_BITS));
  localparam logic [PW:0] MAX_POS = (PW+1)'(sat_max_pos(OPERAND_BITS));
  localparam logic [PW:0] MIN_MAG = (PW+1)'(sat_min_mag(OPERAND_BITS));

  logic [PW:0] biased;
  logic [PW:0] rounded;

  always_comb begin
    biased  = {1'b0, mag} + HALF;
    rounded = biased >> (FRAC_BITS - 1);
    result  = '0;
    // Sign is applied to the rounded magnitude, so a zero product stays 0.
    if (neg) begin
      if (rounded >= MIN_MAG)
        result = $signed(MIN_MAG[OPERAND_BITS-1:0]);
      else
        result = -$signed(rounded[OPERAND_BITS-1:0]);
    end else begin
      if (rounded > MAX_POS)
        result = $signed(MAX_POS[OPERAND_BITS-1:0]);
      else
        result = $signed(rounded[OPERAND_BITS-1:0]);
    end
  end

endmodule

// File: rtl/frac_uint_multiplier.sv
// Sequential signed-fraction x unsigned multiplier: LSB-first shift-add over
// |Q|, then round/sign/saturate into P_OUT, free-running while CE is high.
module frac_uint_multiplier
  import theremin_arith_pkg::*;
#(
  parameter int FRAC_BITS    = 25,
  parameter int OPERAND_BITS = 30
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           CE,
  input  logic signed [FRAC_BITS-1:0]    Q_IN,
  input  logic [OPERAND_BITS-1:0]        B_IN,
  output logic                           IN_READY,
  output logic                           RESULT_READY,
  output logic signed [OPERAND_BITS-1:0] P_OUT
);

  localparam int PW    = FRAC_BITS + OPERAND_BITS;
  localparam int CNT_W = $clog2(FRAC_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(FRAC_BITS - 1);

  mul_state_t                     state;
  logic [CNT_W-1:0]               cnt;
  logic                           neg;
  logic [FRAC_BITS-1:0]           q_mag;
  logic [PW-1:0]                  b_sh;
  logic [PW-1:0]                  acc;
  logic [FRAC_BITS-1:0]           q_abs;
  logic signed [OPERAND_BITS-1:0] rs_result;

  // Two's-complement negate of -2^(FRAC_BITS-1) reads back as +2^(FRAC_BITS-1)
  // when viewed unsigned, so the full-scale negative fraction stays exact.
  always_comb begin
    q_abs = Q_IN[FRAC_BITS-1] ? $unsigned(-Q_IN) : $unsigned(Q_IN);
  end

  frac_round_sat #(
    .FRAC_BITS    (FRAC_BITS),
    .OPERAND_BITS (OPERAND_BITS)
  ) u_round_sat (
    .mag    (acc),
    .neg    (neg),
    .result (rs_result)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      IN_READY     <= 1'b0;
      RESULT_READY <= 1'b0;
      P_OUT        <= '0;
    end else if (CE) begin
      case (state)
        ST_IDLE: begin
          state    <= ST_READY;
          IN_READY <= 1'b1;
        end
        ST_READY: begin
          state    <= ST_CAPTURE;
          IN_READY <= 1'b0;
        end
        ST_CAPTURE: begin
          neg   <= Q_IN[FRAC_BITS-1];
          q_mag <= q_abs;
          b_sh  <= {{FRAC_BITS{1'b0}}, B_IN};
          acc   <= '0;
          cnt   <= '0;
          state <= ST_MUL;
        end
        ST_MUL: begin
          if (q_mag[0])
            acc <= acc + b_sh;
          q_mag <= q_mag >> 1;
          b_sh  <= b_sh << 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_ITER)
            state <= ST_FINISH;
        end
        ST_FINISH: begin
          P_OUT        <= rs_result;
          RESULT_READY <= 1'b1;
          state        <= ST_DONE;
        end
        ST_DONE: begin
          RESULT_READY <= 1'b0;
          IN_READY     <= 1'b1;
          state        <= ST_READY;
        end
        default: begin
          state        <= ST_IDLE;
          IN_READY     <= 1'b0;
          RESULT_READY <= 1'b0;
        end
      endcase
    end
  end

endmodule
